// File: rtl/fifo_wr_arbiter.sv
// Burst-based write-port arbiter: NREQ producers share one FIFO write port.
// Default is round-robin; define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din_bus,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [W-1:0]      fifo_din,
  output logic              busy
);

  localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            CW        = 4;
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;

  logic [W-1:0]    din_slice [NREQ];
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            write_en;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign din_slice[gi] = din_bus[gi*W +: W];
    end
  endgenerate

  // Scan in reverse search order so the earliest candidate is the last one written.
  always_comb begin
    win_idx  = '0;
    cand_idx = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_idx = IW'(k);
      if (req[cand_idx]) win_idx = cand_idx;
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      cand_idx = IW'((int'(last_reg) + k) % NREQ);
      if (req[cand_idx]) win_idx = cand_idx;
    end
`endif
  end

  assign write_en = (state_reg == BURST) && req[owner_reg] && !fifo_full;
  assign fifo_wr  = write_en;
  assign fifo_din = write_en ? din_slice[owner_reg] : '0;
  assign ack      = write_en ? grant_reg : '0;
  assign grant    = grant_reg;
  assign busy     = (state_reg == BURST);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req && !fifo_full) begin
          state_next     = BURST;
          grant_next     = NREQ'(1) << win_idx;
          owner_next     = win_idx;
          burst_cnt_next = '0;
        end
      end
      BURST: begin
        // A full stall holds everything; only a withdrawn request or the last slot ends the burst.
        if (!req[owner_reg] || (write_en && burst_cnt_reg == CNT_LAST)) begin
          state_next     = IDLE;
          grant_next     = '0;
          last_next      = owner_reg;
          burst_cnt_next = '0;
        end else if (write_en) begin
          burst_cnt_next = burst_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      owner_reg     <= '0;
      last_reg      <= LAST_INIT;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle comparison against a grant/usage
// model plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int W         = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din_bus;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              fifo_full;
  logic              fifo_wr;
  logic [W-1:0]      fifo_din;
  logic              busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .W(W), .MAX_BURST(MAX_BURST)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .din_bus   (din_bus),
    .ack       (ack),
    .grant     (grant),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Producers: each holds a byte list and advances on its ack.
  logic [W-1:0]    pdata [NREQ][DEPTH];
  int              phead [NREQ];
  int              plen  [NREQ];
  logic [NREQ-1:0] ack_seen = '0;
  logic [W-1:0]    wr_log [$];
  int              ack_cnt [NREQ];

  // Model: who owns the port (-1 = nobody), writes used in this grant, last owner.
  int m_owner = -1;
  int m_used  = 0;
  int m_last  = NREQ - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [NREQ-1:0] r, input int last);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int s = 1; s <= NREQ; s++) if (r[(last + s) % NREQ]) return (last + s) % NREQ;
`endif
    return -1;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_owner = -1; m_used = 0; m_last = NREQ - 1;
    end else if (m_owner < 0) begin
      if (req != '0 && !fifo_full) begin
        m_owner = m_pick(req, m_last);
        m_used  = 0;
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (!fifo_full) begin
      m_used++;
      if (m_used == MAX_BURST) begin
        m_last = m_owner; m_owner = -1;
      end
    end
  end

  initial forever begin
    logic [NREQ-1:0] exp_grant, exp_ack;
    logic            exp_wr;
    logic [W-1:0]    exp_din;
    int              o;
    @(negedge clock);
    o         = (m_owner < 0) ? 0 : m_owner;
    exp_grant = (m_owner >= 0) ? (NREQ'(1) << o) : '0;
    exp_wr    = (m_owner >= 0) && req[o] && !fifo_full;
    exp_din   = exp_wr ? din_bus[o*W +: W] : '0;
    exp_ack   = exp_wr ? exp_grant : '0;
    check("grant", 32'(grant), 32'(exp_grant));
    check("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
    check("fifo_din", 32'(fifo_din), 32'(exp_din));
    check("ack", 32'(ack), 32'(exp_ack));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    ack_seen = ack;
    if (fifo_wr) wr_log.push_back(fifo_din);
    for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
  end

  task automatic drive_producers();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (phead[i] < plen[i]);
      din_bus[i*W +: W] = (phead[i] < plen[i]) ? pdata[i][phead[i]] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) if (ack_seen[i]) phead[i]++;
    drive_producers();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0; plen[i] = 0; ack_cnt[i] = 0;
    end
    wr_log.delete();
    drive_producers();
  endtask

  task automatic load_seq(input int i, input int n, input logic [W-1:0] first, input int step);
    for (int j = 0; j < n; j++) pdata[i][j] = W'(int'(first) + j * step);
    phead[i] = 0;
    plen[i]  = n;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fifo_full = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_full = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr", 32'(fifo_wr), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Producer 0 sends "hola" as one full burst.
    clear_all();
    pdata[0][0] = 8'h68; pdata[0][1] = 8'h6f; pdata[0][2] = 8'h6c; pdata[0][3] = 8'h61;
    plen[0] = 4;
    drive_producers();
    @(negedge clock);
    check("s1_idle_grant", 32'(grant), 32'h0);
    check("s1_idle_wr", 32'(fifo_wr), 32'h0);
    tick();
    @(negedge clock);
    check("s1_grant", 32'(grant), 32'h1);
    check("s1_first_wr", 32'(fifo_wr), 32'h1);
    check("s1_first_din", 32'(fifo_din), 32'h68);
    repeat (6) tick();
    @(negedge clock);
    check("s1_nwrites", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      check("s1_b0", 32'(wr_log[0]), 32'h68);
      check("s1_b1", 32'(wr_log[1]), 32'h6f);
      check("s1_b2", 32'(wr_log[2]), 32'h6c);
      check("s1_b3", 32'(wr_log[3]), 32'h61);
    end
    check("s1_ack0", 32'(ack_cnt[0]), 32'd4);
    check("s1_busy_end", 32'(busy), 32'h0);
    check("s1_grant_end", 32'(grant), 32'h0);

    // All four stream their index byte: 4 writes, 1 bubble, rotating owner.
    do_reset();
    for (int i = 0; i < NREQ; i++) load_seq(i, DEPTH, W'(8'h30 + i), 0);
    drive_producers();
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      check($sformatf("s2_wr_c%0d", k), 32'(fifo_wr), 32'(k % 5 != 0));
      if (k % 5 != 0) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
        check($sformatf("s2_din_c%0d", k), 32'(fifo_din), 32'h30);
`else
        check($sformatf("s2_din_c%0d", k), 32'(fifo_din), 32'(8'h30 + (k / 5) % 4));
`endif
      end
      tick();
    end

    // Producer 2 stalls on full for 5 cycles after its second write.
    do_reset();
    load_seq(2, 8, 8'h41, 1);
    drive_producers();
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("s3_stall_wr%0d", k), 32'(fifo_wr), 32'h0);
      check($sformatf("s3_stall_ack%0d", k), 32'(ack), 32'h0);
      check($sformatf("s3_stall_grant%0d", k), 32'(grant), 32'h4);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clock);
    check("s3_resume_c", 32'(fifo_din), 32'h43);
    tick();
    @(negedge clock);
    check("s3_resume_d", 32'(fifo_din), 32'h44);
    tick();
    @(negedge clock);
    check("s3_end_wr", 32'(fifo_wr), 32'h0);
    check("s3_end_grant", 32'(grant), 32'h0);
    check("s3_ack2", 32'(ack_cnt[2]), 32'd4);

    // Producer 1 withdraws after one write; producer 3 is next.
    do_reset();
    load_seq(1, 1, 8'h78, 0);
    load_seq(3, 8, 8'h79, 0);
    drive_producers();
    tick();
    @(negedge clock);
    check("s4_grant1", 32'(grant), 32'h2);
    check("s4_din1", 32'(fifo_din), 32'h78);
    tick();
    @(negedge clock);
    check("s4_withdraw_wr", 32'(fifo_wr), 32'h0);
    tick();
    @(negedge clock);
    check("s4_bubble_grant", 32'(grant), 32'h0);
    check("s4_bubble_busy", 32'(busy), 32'h0);
    tick();
    @(negedge clock);
    check("s4_grant3", 32'(grant), 32'h8);
    check("s4_din3", 32'(fifo_din), 32'h79);

    // Asynchronous reset in the middle of a write burst.
    do_reset();
    load_seq(0, 8, 8'h41, 1);
    drive_producers();
    repeat (2) tick();
    @(negedge clock);
    check("s5_wr_before", 32'(fifo_wr), 32'h1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_wr", 32'(fifo_wr), 32'h0);
    check("s5_async_ack", 32'(ack), 32'h0);
    check("s5_async_grant", 32'(grant), 32'h0);
    check("s5_async_busy", 32'(busy), 32'h0);
    clear_all();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) load_seq(i, DEPTH, W'(8'h30 + i), 0);
    drive_producers();
    tick();
    @(negedge clock);
    check("s5_first_grant", 32'(grant), 32'h1);
    check("s5_first_din", 32'(fifo_din), 32'h30);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the byte FIFO (`fifo`: reset, clock, rd, wr, din) between NREQ independent producers.
- Round-robin arbitration, burst-based: a winner keeps the port for up to MAX_BURST consecutive writes.
- Honours FIFO full back-pressure.
- Returns a per-producer ack for every byte actually written.
- Sits between the producer blocks (command/uart sources) and the FIFO instance.

Parameters:
- NREQ, 4, number of requesting producers (2..8).
- W, 8, data width; must match FIFO din width.
- MAX_BURST, 4, maximum writes per grant before arbitration is re-run (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  req[i]=1: producer i has a byte on its din slice.
- din_bus  in  NREQ*W  producer i data on bits [i*W +: W].
- ack  out  NREQ  ack[i]=1 in the cycle producer i's byte is written; producer advances on it.
- grant  out  NREQ  one-hot current owner, registered; all zero when idle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  FIFO write strobe (to fifo.wr).
- fifo_din  out  W  FIFO write data (to fifo.din).
- busy  out  1  1 while in BURST state.

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE, grant=0, busy=0, burst_cnt=0.
  - last pointer = NREQ-1, so requester 0 has first priority after reset.
  - fifo_wr and ack are 0 while reset is high; no partial write is ever emitted.
- States: IDLE, BURST.
- IDLE:
  - If |req and !fifo_full, the winner is the first i with req[i]=1, searching from last+1 upward with wrap-around modulo NREQ.
  - At the next edge: grant<=onehot(winner), state<=BURST, burst_cnt<=0.
  - No write occurs in IDLE.
- BURST, write cycle:
  - Combinational: fifo_wr = req[g] & !fifo_full; fifo_din = din_bus slice g; ack[g] = fifo_wr; all other ack bits 0.
  - fifo_din = 0 when fifo_wr=0.
  - burst_cnt increments on each write.
- BURST, exit to IDLE at the edge where any of these holds:
  - req[g]=0.
  - A write occurs with burst_cnt==MAX_BURST-1.
- On exit: last<=g, grant<=0.
- fifo_full in BURST: stall in place with no write and no ack. The grant is kept and burst_cnt is frozen; a full stall does not consume the burst.
- Latency: req rising in an idle arbiter to the first fifo_wr is 1 cycle (the grant edge); fifo_wr is then asserted in the cycle after that grant edge. Back-to-back writes from one owner run at 1 byte/cycle.
- Arbitration bubble: exactly one IDLE cycle between consecutive grants.
- Fairness: with all req high, grants rotate 0,1,2,3,0,... and each grant gets MAX_BURST writes.
- Withdrawn request: a requester that deasserts req while granted loses the grant. Its unused burst slots are not carried over.
- Invariants: grant is always one-hot or zero. ack is a subset of grant.

Optional Feature:
- Macro: FIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The IDLE winner is the lowest-index requester; the last pointer is not used. MAX_BURST still applies, so the lowest index re-wins after each bubble.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then req=4'b0001, din0 sequence "h","o","l","a" (MAX_BURST=4), fifo_full=0 -> grant=0001 one cycle after req; fifo_wr high 4 consecutive cycles with bytes "h","o","l","a"; ack[0] pulses 4 times; back to IDLE; busy falls.
- req=4'b1111, each producer streams its own index byte (0x30+i), run 32 cycles -> write order is four 0x30, bubble, four 0x31, bubble, four 0x32, bubble, four 0x33, bubble, repeating; no write during bubbles.
- Producer 2 granted, fifo_full forced 1 after its 2nd write for 5 cycles -> no fifo_wr and no ack for those 5 cycles; grant stays 0100; after release exactly 2 more writes, then IDLE.
- Producer 1 granted, req[1] drops after 1 write while req[3]=1 -> IDLE for one cycle, then grant=1000 (round-robin from 1 skips 2).
- Assert reset mid-burst with fifo_wr high -> fifo_wr, ack, grant go 0 immediately (asynchronously); after release, req=1111 grants producer 0 first.
- With FIFO_ARB_FIXED_PRIO_EN and req=1111 -> only producer 0 is ever granted (4 writes, 1 bubble, repeat); without the macro, the rotation from the all-request scenario holds.
